// File: rtl/mips_hazard_forward_unit.sv
// Hazard detection and operand forwarding for the 5-stage MIPS pipeline.
// Keeps shadow EX/MEM/WB copies of each instruction's register-usage fields and
// derives the EX operand mux selects and the load-use stall from them.
//
// Ports:
//   clock, nReset          core clock, asynchronous active-low reset
//   idValid .. idMemRead   register-usage fields of the instruction in ID
//   flush                  taken branch/jump; squashes the ID instruction
//   stall                  combinational load-use stall (holds PC and IF/ID)
//   forwardA, forwardB     EX operand selects: 0 = regfile, 1 = WB, 2 = MEM ALU
//   stallCount             saturating count of load-use stall cycles
module mips_hazard_forward_unit #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned COUNT_WIDTH    = 32
) (
  input  logic                      clock,
  input  logic                      nReset,
  input  logic                      idValid,
  input  logic [REG_ADDR_WIDTH-1:0] idRs,
  input  logic [REG_ADDR_WIDTH-1:0] idRt,
  input  logic                      idUsesRs,
  input  logic                      idUsesRt,
  input  logic [REG_ADDR_WIDTH-1:0] idDest,
  input  logic                      idRegWrite,
  input  logic                      idMemRead,
  input  logic                      flush,
  output logic                      stall,
  output logic [1:0]                forwardA,
  output logic [1:0]                forwardB,
  output logic [COUNT_WIDTH-1:0]    stallCount
);

  localparam int unsigned RW = REG_ADDR_WIDTH;
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_WB  = 2'd1;
  localparam logic [1:0] SEL_MEM = 2'd2;

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic          uses_rs;
    logic          uses_rt;
    logic [RW-1:0] dest;
    logic          reg_write;
    logic          mem_read;
  } stage_t;

  stage_t ex_q, mem_q, wb_q;
  stage_t id_entry;

  logic ex_qual, mem_qual, wb_qual;
  logic mem_fwd_ok;
  logic raw_load;

  // Writers of $0 are ignored everywhere: they neither forward nor stall.
  assign ex_qual  = ex_q.valid  && ex_q.reg_write  && (ex_q.dest  != '0);
  assign mem_qual = mem_q.valid && mem_q.reg_write && (mem_q.dest != '0);
  assign wb_qual  = wb_q.valid  && wb_q.reg_write  && (wb_q.dest  != '0);

  // A load in MEM has no ALU result worth forwarding; its data appears in WB.
  assign mem_fwd_ok = mem_qual && !mem_q.mem_read;

  // Load-use hazard against the instruction currently in EX.
  assign raw_load = idValid && ex_qual && ex_q.mem_read &&
                    ((idUsesRs && (idRs == ex_q.dest)) ||
                     (idUsesRt && (idRt == ex_q.dest)));

  // Flush wins: a squashed instruction has nothing to wait for.
  assign stall = raw_load && !flush;

  // Next EX entry: the ID instruction, or a bubble on stall/flush.
  always_comb begin
    id_entry           = '0;
    id_entry.valid     = idValid && !stall && !flush;
    id_entry.rs        = idRs;
    id_entry.rt        = idRt;
    id_entry.uses_rs   = idUsesRs;
    id_entry.uses_rt   = idUsesRt;
    id_entry.dest      = idDest;
    id_entry.reg_write = idRegWrite;
    id_entry.mem_read  = idMemRead;
  end

  // Shadow pipeline of register-usage fields.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= id_entry;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      stallCount <= '0;
    end else if (stall && (stallCount != CNT_MAX)) begin
      stallCount <= stallCount + COUNT_WIDTH'(1);
    end
  end

  // MEM has priority over WB because it holds the younger result.
  function automatic logic [1:0] fwd_sel(
    input logic          ex_valid,
    input logic          uses,
    input logic [RW-1:0] src,
    input logic          mem_ok,
    input logic [RW-1:0] mem_dest,
    input logic          wb_ok,
    input logic [RW-1:0] wb_dest
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (ex_valid && uses) begin
      if (mem_ok && (mem_dest == src)) begin
        sel = SEL_MEM;
      end else if (wb_ok && (wb_dest == src)) begin
        sel = SEL_WB;
      end
    end
    return sel;
  endfunction

  // Selects depend on registered state only.
  always_comb begin
    forwardA = fwd_sel(ex_q.valid, ex_q.uses_rs, ex_q.rs,
                       mem_fwd_ok, mem_q.dest, wb_qual, wb_q.dest);
    forwardB = fwd_sel(ex_q.valid, ex_q.uses_rt, ex_q.rt,
                       mem_fwd_ok, mem_q.dest, wb_qual, wb_q.dest);
  end

  // Source fields carried through MEM/WB for completeness but not consulted.
  logic unused_fields;
  assign unused_fields = ^{mem_q.rs, mem_q.rt, mem_q.uses_rs, mem_q.uses_rt,
                           wb_q.rs, wb_q.rt, wb_q.uses_rs, wb_q.uses_rt,
                           wb_q.mem_read};

endmodule

// File: tb/tb_mips_hazard_forward_unit.sv
// Directed-vector bench for mips_hazard_forward_unit with a queue scoreboard.
module tb_mips_hazard_forward_unit;

  localparam int unsigned RW = 5;
  localparam int unsigned CW = 4;

  localparam int K_NOP = 0;
  localparam int K_R   = 1;
  localparam int K_I   = 2;
  localparam int K_LW  = 3;

  logic          clock = 1'b0;
  logic          nReset;
  logic          idValid;
  logic [RW-1:0] idRs, idRt, idDest;
  logic          idUsesRs, idUsesRt, idRegWrite, idMemRead;
  logic          flush;
  logic          stall;
  logic [1:0]    forwardA, forwardB;
  logic [CW-1:0] stallCount;

  mips_hazard_forward_unit #(.REG_ADDR_WIDTH(RW), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .nReset(nReset), .idValid(idValid), .idRs(idRs), .idRt(idRt),
    .idUsesRs(idUsesRs), .idUsesRt(idUsesRt), .idDest(idDest),
    .idRegWrite(idRegWrite), .idMemRead(idMemRead), .flush(flush),
    .stall(stall), .forwardA(forwardA), .forwardB(forwardB),
    .stallCount(stallCount)
  );

  always #5 clock = ~clock;

  typedef struct {
    int            tag;
    logic          stall;
    logic [1:0]    fa;
    logic [1:0]    fb;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   stim_done = 1'b0;

  task automatic chk(input int tag, input string what, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL cycle %0d %s: got %0d expected %0d", tag, what, act, req);
    end
  endtask

  // Monitor: outputs are compared mid-cycle, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.tag, "stall",      int'(stall),      int'(e.stall));
        chk(e.tag, "forwardA",   int'(forwardA),   int'(e.fa));
        chk(e.tag, "forwardB",   int'(forwardB),   int'(e.fb));
        chk(e.tag, "stallCount", int'(stallCount), int'(e.cnt));
      end
    end
  end

  // One cycle: drive ID fields just after the edge and queue the expected outputs.
  task automatic step(input bit rn, input int kind, input int rs, input int rt,
                      input int rd, input bit fl, input bit es, input int efa,
                      input int efb, input int ecnt);
    exp_t e;
    @(posedge clock);
    #1;
    cyc++;
    nReset     = rn;
    flush      = fl;
    idValid    = 1'b0;
    idRs       = '0;
    idRt       = '0;
    idDest     = '0;
    idUsesRs   = 1'b0;
    idUsesRt   = 1'b0;
    idRegWrite = 1'b0;
    idMemRead  = 1'b0;
    case (kind)
      K_R: begin
        idValid = 1'b1; idRs = RW'(rs); idRt = RW'(rt); idDest = RW'(rd);
        idUsesRs = 1'b1; idUsesRt = 1'b1; idRegWrite = 1'b1;
      end
      K_I, K_LW: begin
        idValid = 1'b1; idRs = RW'(rs); idRt = RW'(rt); idDest = RW'(rt);
        idUsesRs = 1'b1; idRegWrite = 1'b1; idMemRead = (kind == K_LW);
      end
      default: ;
    endcase
    e.tag   = cyc;
    e.stall = es;
    e.fa    = 2'(efa);
    e.fb    = 2'(efb);
    e.cnt   = CW'(ecnt);
    exp_q.push_back(e);
  endtask

  initial begin
    int c;
    nReset = 1'b0; flush = 1'b0; idValid = 1'b0; idRs = '0; idRt = '0;
    idDest = '0; idUsesRs = 1'b0; idUsesRt = 1'b0; idRegWrite = 1'b0; idMemRead = 1'b0;

    //   rn kind  rs rt rd fl  st fa fb cnt
    step(0, K_NOP, 0, 0, 0, 0, 0, 0, 0, 0);   // in reset
    // add $3,$1,$2 ; sub $4,$3,$5 back-to-back
    step(1, K_R,   1, 2, 3, 0, 0, 0, 0, 0);
    step(1, K_R,   3, 5, 4, 0, 0, 0, 0, 0);
    step(1, K_NOP, 0, 0, 0, 0, 0, 2, 0, 0);   // sub in EX, add in MEM
    // same pair with a nop between
    step(1, K_R,   1, 2, 3, 0, 0, 0, 0, 0);
    step(1, K_NOP, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, K_R,   3, 5, 4, 0, 0, 0, 0, 0);
    step(1, K_NOP, 0, 0, 0, 0, 0, 1, 0, 0);   // sub in EX, add in WB
    // lw $2,0($1) ; add $6,$2,$2
    step(1, K_LW,  1, 2, 0, 0, 0, 0, 0, 0);
    step(1, K_R,   2, 2, 6, 0, 1, 0, 0, 0);   // hazard
    step(1, K_R,   2, 2, 6, 0, 0, 0, 0, 1);   // held add, bubble in EX
    step(1, K_NOP, 0, 0, 0, 0, 0, 1, 1, 1);   // add in EX, lw in WB
    // addi $0,$1,5 ; add $7,$0,$0
    step(1, K_I,   1, 0, 0, 0, 0, 0, 0, 1);
    step(1, K_R,   0, 0, 7, 0, 0, 0, 0, 1);
    step(1, K_NOP, 0, 0, 0, 0, 0, 0, 0, 1);
    // lw $0 ; add $7,$0,$0 must not stall
    step(1, K_LW,  1, 0, 0, 0, 0, 0, 0, 1);
    step(1, K_R,   0, 0, 7, 0, 0, 0, 0, 1);
    step(1, K_NOP, 0, 0, 0, 0, 0, 0, 0, 1);
    // load-use squashed by flush
    step(1, K_LW,  1, 2, 0, 0, 0, 0, 0, 1);
    step(1, K_R,   2, 2, 6, 1, 0, 0, 0, 1);
    step(1, K_NOP, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, K_NOP, 0, 0, 0, 0, 0, 0, 0, 1);
    // addi $8 ; or $8 ; and $9,$8,$8 -> MEM wins over WB
    step(1, K_I,   1, 8, 0, 0, 0, 0, 0, 1);
    step(1, K_R,   1, 2, 8, 0, 0, 0, 0, 1);
    step(1, K_R,   8, 8, 9, 0, 0, 0, 0, 1);
    step(1, K_NOP, 0, 0, 0, 0, 0, 2, 2, 1);
    // repeated load-use pairs drive the counter into saturation
    for (int i = 0; i < 18; i++) begin
      c = (1 + i > 15) ? 15 : 1 + i;
      step(1, K_LW, 1, 2, 0, 0, 0, (i == 0) ? 0 : 1, (i == 0) ? 0 : 1, c);
      step(1, K_R,  2, 2, 6, 0, 1, 0, 0, c);
      step(1, K_R,  2, 2, 6, 0, 0, 0, 0, (2 + i > 15) ? 15 : 2 + i);
    end
    step(1, K_NOP, 0, 0, 0, 0, 0, 1, 1, 15);
    // reset mid-stream with a pending load-use and a MEM match on lw's rs
    step(1, K_I,   0, 1, 0, 0, 0, 0, 0, 15);  // addi $1,$0,1
    step(1, K_LW,  1, 2, 0, 0, 0, 0, 0, 15);
    step(0, K_R,   2, 2, 6, 0, 0, 0, 0, 0);   // would be stall=1, fa=2
    step(1, K_R,   2, 2, 6, 0, 0, 0, 0, 0);
    step(1, K_NOP, 0, 0, 0, 0, 0, 0, 0, 0);
    stim_done = 1'b1;
  end

  initial begin
    int budget;
    wait (stim_done);
    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(posedge clock);
      budget++;
    end
    n_checks++;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
